// File: rtl/l4_weight_fetch.sv
`timescale 1ns/1ps
// Layer-4 weight sequencer: walks the weight ROM in 16-lane strides and streams 400 tagged beats.
// Start-to-valid 2 cycles, 1 beat/cycle; issue throttled by FD credits, head held while not ready.
module l4_weight_fetch #(
    parameter int DEPTH   = 6400,
    parameter int LANES   = 16,
    parameter int NEURONS = 10,
    parameter int AW      = 13,
    parameter int DW      = 9,
    parameter int FD      = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic [AW-1:0] o_rom_addr,
    input  logic [DW-1:0] i_rom_dout [LANES-1:0],
    output logic [DW-1:0] o_w_data [LANES-1:0],
    output logic          o_w_valid,
    input  logic          i_w_ready,
    output logic [3:0]    o_w_neuron,
    output logic          o_w_last_neuron,
    output logic          o_w_last,
    output logic          o_busy,
    output logic          o_done
);
    localparam int BEATS = DEPTH / LANES;
    localparam int BPN   = DEPTH / (LANES * NEURONS);
    localparam int KW    = $clog2(BEATS);
    localparam int IW    = $clog2(BPN);
    localparam int PW    = $clog2(FD + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t r_state, w_state_nxt;

    logic [AW-1:0] r_addr;
    logic [KW-1:0] r_beat;
    logic [IW-1:0] r_inn;
    logic [3:0]    r_nrn;
    logic          r_pend;
    logic [3:0]    r_pend_nrn;
    logic          r_pend_lastn;
    logic          r_pend_last;
    logic [DW-1:0] r_fifo_dat [FD][LANES];
    logic [3:0]    r_fifo_nrn [FD];
    logic          r_fifo_lastn [FD];
    logic          r_fifo_last [FD];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
    logic          r_done;

    logic          w_pop, w_room, w_issue, w_accept, w_beat_last, w_inn_last;
    logic [PW:0]   w_cnt;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_w_valid   = (r_count != '0);
    assign w_pop       = o_w_valid && i_w_ready;
    // A pop this cycle frees a slot immediately, so issue never bubbles under full flow.
    assign w_cnt       = {1'b0, r_count} + (PW+1)'(r_pend);
    assign w_room      = (w_cnt - (PW+1)'(w_pop)) < (PW+1)'(FD);
    assign w_beat_last = (r_beat == KW'(BEATS - 1));
    assign w_inn_last  = (r_inn == IW'(BPN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_issue = w_room;
                if (w_issue && w_beat_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && r_fifo_last[r_rd_ptr]) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_beat       <= '0;
            r_inn        <= '0;
            r_nrn        <= '0;
            r_pend       <= 1'b0;
            r_pend_nrn   <= '0;
            r_pend_lastn <= 1'b0;
            r_pend_last  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pend <= w_issue;
            r_done <= (r_state == S_DRAIN) && w_pop && r_fifo_last[r_rd_ptr];
            if (w_issue) begin
                r_pend_nrn   <= r_nrn;
                r_pend_lastn <= w_inn_last;
                r_pend_last  <= w_beat_last;
            end
            if (w_accept) begin
                r_addr <= '0;
                r_beat <= '0;
                r_inn  <= '0;
                r_nrn  <= '0;
            end else if (w_issue && !w_beat_last) begin
                r_addr <= r_addr + AW'(LANES);
                r_beat <= r_beat + 1'b1;
                r_inn  <= w_inn_last ? '0 : r_inn + 1'b1;
                r_nrn  <= w_inn_last ? r_nrn + 1'b1 : r_nrn;
            end
        end
    end

    // ROM data for the beat issued last cycle lands in the buffer; credits guarantee a free slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FD; i++) begin
                for (int j = 0; j < LANES; j++) r_fifo_dat[i][j] <= '0;
                r_fifo_nrn[i]   <= '0;
                r_fifo_lastn[i] <= 1'b0;
                r_fifo_last[i]  <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_pend) begin
                for (int j = 0; j < LANES; j++) r_fifo_dat[r_wr_ptr][j] <= i_rom_dout[j];
                r_fifo_nrn[r_wr_ptr]   <= r_pend_nrn;
                r_fifo_lastn[r_wr_ptr] <= r_pend_lastn;
                r_fifo_last[r_wr_ptr]  <= r_pend_last;
                r_wr_ptr               <= f_next(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            case ({r_pend, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) o_w_data[j] = r_fifo_dat[r_rd_ptr][j];
    end

    assign o_w_neuron      = r_fifo_nrn[r_rd_ptr];
    assign o_w_last_neuron = r_fifo_lastn[r_rd_ptr];
    assign o_w_last        = r_fifo_last[r_rd_ptr];
    assign o_rom_addr      = r_addr;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;

endmodule

// File: tb/tb_l4_weight_fetch.sv
`timescale 1ns/1ps
// Bench for l4_weight_fetch: ROM model word n = n mod 512, scoreboard of all beats per pass,
// cycle table for the start/backpressure window, and sequences for stall, ignore-start, reset, restart.
module tb_l4_weight_fetch;
    localparam int LANES = 16;
    localparam int DW    = 9;
    localparam int AW    = 13;
    localparam int BEATS = 400;
    localparam int BPN   = 40;

    logic          i_clk = 1'b0;
    logic          i_rst, i_start, i_w_ready;
    logic [AW-1:0] o_rom_addr;
    logic [DW-1:0] rom_dout [LANES-1:0];
    logic [DW-1:0] o_w_data [LANES-1:0];
    logic          o_w_valid, o_w_last_neuron, o_w_last, o_busy, o_done;
    logic [3:0]    o_w_neuron;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, sb_k = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = 0, max_lead = 0;
    int mon_lead, mon_nerr;
    bit prev_valid = 1'b0;

    typedef struct {
        bit rdy;
        int addr;
        bit vld;
        int head;
    } vec_t;
    vec_t tbl[10];

    l4_weight_fetch dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_rom_addr(o_rom_addr),
        .i_rom_dout(rom_dout), .o_w_data(o_w_data), .o_w_valid(o_w_valid), .i_w_ready(i_w_ready),
        .o_w_neuron(o_w_neuron), .o_w_last_neuron(o_w_last_neuron), .o_w_last(o_w_last),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) rom_dout[i] <= DW'((int'(o_rom_addr) + i) % 512);
    end

    function automatic int exp_lane(input int k, input int i);
        return (16 * k + i) % 512;
    endfunction

    function automatic logic [31:0] exp_tags(input int k);
        logic [5:0] t;
        t = {4'(k / BPN), (k % BPN) == BPN - 1, k == BEATS - 1};
        return 32'(t);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_busy) begin
            mon_lead = int'(o_rom_addr) / LANES - sb_k;
            if (mon_lead > max_lead) max_lead = mon_lead;
        end
        if (o_w_valid && !prev_valid) first_valid_cyc = cyc;
        prev_valid = o_w_valid;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("beats_per_pass", done_cnt, 32'(sb_k), 32'(BEATS));
            sb_k = 0;
        end
        if (o_w_valid && i_w_ready) begin
            mon_nerr = 0;
            for (int i = 0; i < LANES; i++)
                if (int'(o_w_data[i]) != exp_lane(sb_k, i)) mon_nerr++;
            check("beat_in_range", sb_k, 32'(sb_k < BEATS), 32'd1);
            check("beat_lanes_wrong", sb_k, 32'(mon_nerr), 32'd0);
            check("beat_tags", sb_k, 32'({o_w_neuron, o_w_last_neuron, o_w_last}), exp_tags(sb_k));
            sb_k++;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_pass(output int s);
        max_lead = 0;
        i_start  = 1'b1;
        step();
        s       = cyc;
        i_start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        int dor;
        dor = 0;
        for (int i = 0; i < LANES; i++) dor |= int'(o_w_data[i]);
        check({tag, "_rom_addr"}, 0, 32'(o_rom_addr), 32'd0);
        check({tag, "_w_data_or"}, 0, 32'(dor), 32'd0);
        check({tag, "_ctl_bits"}, 0,
              32'({o_w_valid, o_w_neuron, o_w_last_neuron, o_w_last, o_busy, o_done}), 32'd0);
    endtask

    task automatic run_until_done(input bit rnd, input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            i_w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            #1;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        check("done_seen", done_cnt, 32'(ok), 32'd1);
    endtask

    task automatic wait_sb(input int target, input bit rnd, input int limit);
        for (int n = 0; n < limit && sb_k < target; n++) begin
            i_w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        check("reach_beat", target, 32'(sb_k), 32'(target));
    endtask

    initial begin
        int s, d0, dc;
        bit ok;

        tbl[0] = '{0,  0, 0, 0};
        tbl[1] = '{0, 16, 0, 0};
        tbl[2] = '{0, 32, 1, 0};
        tbl[3] = '{0, 48, 1, 0};
        tbl[4] = '{0, 48, 1, 0};
        tbl[5] = '{1, 48, 1, 0};
        tbl[6] = '{1, 64, 1, 1};
        tbl[7] = '{0, 80, 1, 2};
        tbl[8] = '{1, 80, 1, 2};
        tbl[9] = '{1, 96, 1, 3};

        i_rst = 1'b0; i_start = 1'b0; i_w_ready = 1'b0;
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("reset");
        i_rst = 1'b0;
        step();

        // Start window with backpressure, cycle by cycle, then drain the pass.
        start_pass(s);
        for (int n = 0; n < 10; n++) begin
            i_w_ready = tbl[n].rdy;
            @(negedge i_clk);
            check("tbl_rom_addr", n, 32'(o_rom_addr), 32'(tbl[n].addr));
            check("tbl_w_valid", n, 32'(o_w_valid), 32'(tbl[n].vld));
            check("tbl_busy", n, 32'(o_busy), 32'd1);
            if (tbl[n].vld) check("tbl_head_lane0", n, 32'(o_w_data[0]), 32'((16 * tbl[n].head) % 512));
            @(posedge i_clk);
            #1;
        end
        run_until_done(1'b0, 1000);
        check("tbl_max_outstanding", 0, 32'(max_lead), 32'd3);

        // Full-throughput pass: exact latency and done timing.
        step();
        d0 = done_cnt;
        start_pass(s);
        run_until_done(1'b0, 1000);
        check("first_valid_latency", 0, 32'(first_valid_cyc - s), 32'd2);
        check("done_cycle", 0, 32'(done_cyc - s), 32'd402);
        check("busy_low_at_done", 0, 32'(o_busy), 32'd0);
        check("done_pulses", 1, 32'(done_cnt - d0), 32'd1);

        // Ten-cycle stall at beat 50.
        step();
        start_pass(s);
        wait_sb(50, 1'b0, 200);
        i_w_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge i_clk);
            check("stall_head_held", j, 32'(o_w_data[0]), 32'd288);
            check("stall_valid", j, 32'(o_w_valid), 32'd1);
            if (j == 9) check("stall_rom_addr_frozen", j, 32'(o_rom_addr), 32'd848);
            @(posedge i_clk);
            #1;
        end
        run_until_done(1'b0, 1000);
        check("stall_max_outstanding", 0, 32'(max_lead), 32'd3);

        // Random ready, start pulses in RUN and in DRAIN are ignored.
        step();
        d0 = done_cnt;
        start_pass(s);
        wait_sb(100, 1'b1, 2000);
        i_start = 1'b1;
        i_w_ready = 1'($urandom_range(0, 1));
        step();
        i_start = 1'b0;
        wait_sb(399, 1'b1, 3000);
        i_w_ready = 1'b0;
        repeat (3) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run_until_done(1'b1, 3000);
        check("rand_outstanding_le3", 0, 32'(max_lead <= 3), 32'd1);
        repeat (5) step();
        check("no_restart_busy", 0, 32'(o_busy), 32'd0);
        check("single_done", 0, 32'(done_cnt - d0), 32'd1);

        // Reset mid-pass at beat 200, then a clean full pass.
        d0 = done_cnt;
        start_pass(s);
        wait_sb(200, 1'b0, 1000);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        check_zero("midrst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb_k  = 0;
        step();
        check("post_rst_idle", 0, 32'({o_busy, o_w_valid}), 32'd0);
        start_pass(s);
        run_until_done(1'b0, 1000);
        check("post_rst_first_valid", 0, 32'(first_valid_cyc - s), 32'd2);
        check("post_rst_done_pulses", 0, 32'(done_cnt - d0), 32'd1);

        // Start held high across done: immediate second pass.
        step();
        d0 = done_cnt;
        start_pass(s);
        wait_sb(395, 1'b0, 1000);
        i_start = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            #1;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        check("held_done_seen", 0, 32'(ok), 32'd1);
        dc = done_cyc;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("restart_busy", 0, 32'(o_busy), 32'd1);
        run_until_done(1'b0, 1000);
        check("restart_first_valid", 0, 32'(first_valid_cyc - dc), 32'd3);
        check("restart_done_pulses", 0, 32'(done_cnt - d0), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l4_weight_fetch.md
# l4_weight_fetch

Layer-4 weight sequencer: reader side of the layer-4 16-lane weight ROM. On `start` it walks the 6400-entry weight ROM in 16-word strides, absorbs the ROM's fixed 1-cycle read latency, and delivers each 16-weight beat to the layer-4 MAC array over a valid/ready handshake, tagged with its output-neuron index. A 3-entry credit-managed buffer gives full throughput (1 beat/cycle) under continuous `w_ready` with no lost or duplicated beats under backpressure.

## Interface
- `DEPTH`, 6400: ROM words.
- `LANES`, 16: weights per beat (ROM read width).
- `NEURONS`, 10: output neurons; beats per neuron `BPN = DEPTH/(LANES*NEURONS)` = 40.
- `AW`, 13: ROM address width. `DW`, 9: weight width.
- `FD`, 3: output buffer depth (credits).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a full pass; sampled only in IDLE.
- `rom_addr` out AW: ROM base address; ROM returns words `rom_addr..rom_addr+15` on `rom_dout` one cycle later.
- `rom_dout` in DW x LANES (`[DW-1:0] rom_dout[LANES-1:0]`): ROM read data.
- `w_data` out DW x LANES: weight beat, lane i = ROM word `16*k+i` for beat k.
- `w_valid` out 1; `w_ready` in 1: beat handshake, transfer when both high.
- `w_neuron` out 4: neuron index of current beat (`k / BPN`).
- `w_last_neuron` out 1: high on beat `k % BPN == BPN-1`.
- `w_last` out 1: high on beat k = 399.
- `busy` out 1: high from start acceptance until final handshake.
- `done` out 1: one-cycle pulse after final handshake.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 -> RUN; `rom_addr`<=0, beat/issue counters cleared, `busy`<=1. Issue of beat 0 occurs in the first RUN cycle.
- Issue: beat k "issued" in a cycle when `rom_addr`=16k is presented and `issue`=1. `issue = RUN && (cnt - pop) < FD`, where `cnt` = in-flight beats (issued, not yet in buffer) + buffer occupancy and `pop = w_valid && w_ready`. On issue `rom_addr` advances by 16 the next edge (except after beat 399).
- Issue of beat k registers a pending flag; next cycle `rom_dout` is captured with its tags (neuron, last_neuron, last) into the FIFO at the end of that cycle.
- After issuing beat 399: RUN -> DRAIN; `rom_addr` holds 6384.
- DRAIN: on handshake of the `w_last` beat -> IDLE, `busy`<=0, `done`<=1 for one cycle.
- FIFO head drives `w_data`/tags; `w_valid` = non-empty. Head contents stable while `w_valid && !w_ready`.
- `start` in RUN/DRAIN ignored. `start` during the `done` cycle (state IDLE) accepted.
- Beat counter 0..399, neuron counter 0..9, in-neuron counter 0..39; no wrap beyond 399 within a pass.
- `rst` asserted any time (incl. mid-pass): immediately IDLE, FIFO and pending flags flushed; all outputs 0 (`rom_addr`=0, `w_data` lanes=0, `w_valid`/`w_neuron`/`w_last_neuron`/`w_last`/`busy`/`done`=0).

## Timing
- Start edge E0 -> `rom_addr`=0 during [E0,E1) -> `rom_dout` valid [E1,E2) -> `w_valid`=1 with beat 0 from E2: latency 2 cycles start-to-valid.
- With `w_ready`=1 continuously: one beat per cycle, beat k valid [E(k+2),E(k+3)); final handshake at E402; `done` high [E402,E403); `busy` falls at E402.
- Outstanding `cnt` never exceeds FD=3; with `w_ready`=0 issue stops after 3 beats outstanding; resumes the same cycle `w_ready` returns (pop credited combinationally).
- No combinational path from `rom_dout` to outputs; `w_ready` affects only issue/pop.

## Test plan
- ROM model preloaded with word n = n mod 512; `start` pulse, `w_ready`=1 -> first `w_valid` 2 cycles after start, 400 consecutive beats, beat k lane i = (16k+i) mod 512, `w_neuron` steps every 40 beats, `w_last_neuron` on beats 39,79..399, `w_last` on 399, `done` one cycle at E402.
- `w_ready` low 10 cycles starting at beat 50 -> `w_data` held at beat 50, `rom_addr` frozen after 3 outstanding, stream resumes with beat 50..399 exactly once each.
- Random `w_ready` (50% duty) -> scoreboard exact in-order match of all 400 beats, `cnt`<=3 asserted throughout.
- `start` pulsed at beat 100 and during DRAIN -> ignored, no restart, single `done`.
- `rst` asserted at beat 200 -> all outputs 0 next sample, IDLE; subsequent `start` produces full pass from beat 0.
- `start` held high across `done` cycle -> second pass begins immediately, `w_valid` 2 cycles later with beat 0.
